ram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the pipeline's dual-port data RAM (write port A: `clka`/`wea`/`addra`/`dina`; read port B: `clkb`/`addrb`/`doutb`). It serialises word read/write requests from master 0 (the CPU MEM stage) and master 1 (the debug/loader path). It drives the RAM ports from registers, waits out the RAM read latency, and returns read data with a one-cycle valid pulse. Both RAM clocks are tied to this block's `clk`.

---
 rtl/ram_port_arbiter_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/ram_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared definitions for the dual-port RAM arbiter: FSM state encoding,
//   the legal read-latency range and a helper that checks a latency value.
//   No ports; imported by ram_port_arbiter and rr_arbiter2.

package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    function automatic logic rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Combinational two-way round-robin pick. The pointer register lives in
//   the parent; this block only decides the winner.
// Ports
//   req_i   [1:0]  request vector, bit n = master n
//   last_i         master granted most recently
//   gnt_o   [1:0]  one-hot winner, all zero when nobody requests

module rr_arbiter2
    import ram_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            // Tie goes to the master that was not served last.
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Serialises word read/write requests from two masters onto a dual-port
//   RAM (write port A, read port B, both clocked by clk_i). One access is
//   outstanding at a time; read data returns with a one-cycle valid pulse.
// Ports
//   clk_i, rst_n_i                      clock, async active-low reset
//   mX_req_i/mX_we_i/mX_addr_i/mX_wdata_i  master X command, held until mX_gnt_o
//   mX_gnt_o                            one-cycle pulse, command issued to RAM
//   mX_rvalid_o, mX_rdata_o             read return pulse and held read data
//   ram_wea_o, ram_addra_o, ram_dina_o  RAM write port A
//   ram_addrb_o, ram_doutb_i            RAM read port B
//
// State    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | sample requests, pick a winner, load the RAM drive registers
// ST_ISSUE | RAM port driven, gnt pulsing; write ends here, read waits
// ST_WAIT  | count out RAM read latency, capture doutb on terminal count

module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,

    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,

    output logic          m0_gnt_o,
    output logic          m1_gnt_o,
    output logic          m0_rvalid_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    output logic [DW-1:0] m1_rdata_o,

    output logic          ram_wea_o,
    output logic [AW-1:0] ram_addra_o,
    output logic [DW-1:0] ram_dina_o,
    output logic [AW-1:0] ram_addrb_o,
    input  logic [DW-1:0] ram_doutb_i
);

    if (!rd_lat_legal(RD_LAT)) begin : g_rd_lat_check
        $error("ram_port_arbiter: RD_LAT must be within 1..3");
    end

    // WAIT lasts RD_LAT cycles, so the down-counter starts at RD_LAT-1 and
    // the capture happens when it reads zero.
    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          wea_q, wea_d;
    logic [AW-1:0] addra_q, addra_d;
    logic [DW-1:0] dina_q, dina_d;
    logic [AW-1:0] addrb_q, addrb_d;

    logic [1:0]    win;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arbiter2 u_rr (
        .req_i  ({m1_req_i, m0_req_i}),
        .last_i (ptr_q),
        .gnt_o  (win)
    );

    assign sel_we    = win[1] ? m1_we_i    : m0_we_i;
    assign sel_addr  = win[1] ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = win[1] ? m1_wdata_i : m0_wdata_i;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        wea_d    = 1'b0;
        addra_d  = addra_q;
        dina_d   = dina_q;
        addrb_d  = addrb_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win != 2'b00) begin
                    owner_d = win[1];
                    ptr_d   = win[1];
                    gnt_d   = win;
                    if (sel_we) begin
                        wea_d   = 1'b1;
                        addra_d = sel_addr;
                        dina_d  = sel_wdata;
                    end else begin
                        addrb_d = sel_addr;
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // wea_q is high in ISSUE exactly when the command is a write.
                if (wea_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (owner_q) begin
                        rdata1_d    = ram_doutb_i;
                        rvalid_d[1] = 1'b1;
                    end else begin
                        rdata0_d    = ram_doutb_i;
                        rvalid_d[0] = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b1;
            cnt_q    <= 2'd0;
            owner_q  <= 1'b0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            wea_q    <= 1'b0;
            addra_q  <= '0;
            dina_q   <= '0;
            addrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            wea_q    <= wea_d;
            addra_q  <= addra_d;
            dina_q   <= dina_d;
            addrb_q  <= addrb_d;
        end
    end

    assign m0_gnt_o    = gnt_q[0];
    assign m1_gnt_o    = gnt_q[1];
    assign m0_rvalid_o = rvalid_q[0];
    assign m1_rvalid_o = rvalid_q[1];
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;
    assign ram_wea_o   = wea_q;
    assign ram_addra_o = addra_q;
    assign ram_dina_o  = dina_q;
    assign ram_addrb_o = addrb_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    localparam logic [31:0] DB  = 32'hDEAD_BEEF;
    localparam logic [31:0] DA  = 32'h1111_1111;
    localparam logic [31:0] DBB = 32'h2222_2222;
    localparam logic [31:0] D9  = 32'hA5A5_0009;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    // instance a: RD_LAT=1, instance b: RD_LAT=3
    logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_wea;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_addra, a_dina, a_addrb, a_doutb;
    logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_wea;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_addra, b_dina, b_addrb, b_doutb;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m0_gnt_o(a_m0_gnt), .m1_gnt_o(a_m1_gnt),
        .m0_rvalid_o(a_m0_rvalid), .m1_rvalid_o(a_m1_rvalid),
        .m0_rdata_o(a_m0_rdata), .m1_rdata_o(a_m1_rdata),
        .ram_wea_o(a_wea), .ram_addra_o(a_addra), .ram_dina_o(a_dina),
        .ram_addrb_o(a_addrb), .ram_doutb_i(a_doutb)
    );

    ram_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m0_gnt_o(b_m0_gnt), .m1_gnt_o(b_m1_gnt),
        .m0_rvalid_o(b_m0_rvalid), .m1_rvalid_o(b_m1_rvalid),
        .m0_rdata_o(b_m0_rdata), .m1_rdata_o(b_m1_rdata),
        .ram_wea_o(b_wea), .ram_addra_o(b_addra), .ram_dina_o(b_dina),
        .ram_addrb_o(b_addrb), .ram_doutb_i(b_doutb)
    );

    // RAM models: write on port A at the edge, read pipeline of depth RD_LAT on port B.
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];

    always @(posedge clk) begin
        if (a_wea) mem_a[a_addra[3:0]] <= a_dina;
        pipe_a <= mem_a[a_addrb[3:0]];
        if (b_wea) mem_b[b_addra[3:0]] <= b_dina;
        pipe_b[0] <= mem_b[b_addrb[3:0]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign a_doutb = pipe_a;
    assign b_doutb = pipe_b[2];

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, v0, v1, wea;
        logic [31:0] addra, dina, addrb, rd0, rd1;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input int r0, input int w0, input logic [31:0] a0, input logic [31:0] d0,
                                input int r1, input int w1, input logic [31:0] a1, input logic [31:0] d1,
                                input int g0, input int g1, input int v0, input int v1, input int wea,
                                input logic [31:0] addra, input logic [31:0] dina, input logic [31:0] addrb,
                                input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.r0 = (r0 != 0); v.w0 = (w0 != 0); v.a0 = a0; v.d0 = d0;
        v.r1 = (r1 != 0); v.w1 = (w1 != 0); v.a1 = a1; v.d1 = d1;
        v.g0 = (g0 != 0); v.g1 = (g1 != 0); v.v0 = (v0 != 0); v.v1 = (v1 != 0);
        v.wea = (wea != 0); v.addra = addra; v.dina = dina; v.addrb = addrb;
        v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    function automatic logic [191:0] outs_a();
        return {27'd0, a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_wea,
                a_addra, a_dina, a_addrb, a_m0_rdata, a_m1_rdata};
    endfunction

    function automatic logic [191:0] outs_b();
        return {27'd0, b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_wea,
                b_addra, b_dina, b_addrb, b_m0_rdata, b_m1_rdata};
    endfunction

    function automatic logic [191:0] exp_of(input vec_t v);
        return {27'd0, v.g0, v.g1, v.v0, v.v1, v.wea, v.addra, v.dina, v.addrb, v.rd0, v.rd1};
    endfunction

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic wait_gnt_b(input int m, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ((m == 0 && b_m0_gnt) || (m == 1 && b_m1_gnt)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit saw;
        int lat;

        //            r0 w0 a0 d0    r1 w1 a1 d1     g0 g1 v0 v1 we addra dina addrb rd0 rd1
        vecs[0]  = mk(1, 1, 5, DB,   0, 0, 0, 0,     1, 0, 0, 0, 1, 5, DB,  0, 0,  0);
        vecs[1]  = mk(0, 0, 0, 0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 5, DB,  0, 0,  0);
        vecs[2]  = mk(0, 0, 0, 0,    1, 0, 5, 0,     0, 1, 0, 0, 0, 5, DB,  5, 0,  0);
        vecs[3]  = mk(0, 0, 0, 0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 5, DB,  5, 0,  0);
        vecs[4]  = mk(0, 0, 0, 0,    0, 0, 0, 0,     0, 0, 0, 1, 0, 5, DB,  5, 0,  DB);
        vecs[5]  = mk(1, 1, 1, DA,   1, 1, 2, DBB,   1, 0, 0, 0, 1, 1, DA,  5, 0,  DB);
        vecs[6]  = mk(0, 0, 0, 0,    1, 1, 2, DBB,   0, 0, 0, 0, 0, 1, DA,  5, 0,  DB);
        vecs[7]  = mk(0, 0, 0, 0,    1, 1, 2, DBB,   0, 1, 0, 0, 1, 2, DBB, 5, 0,  DB);
        vecs[8]  = mk(0, 0, 0, 0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 2, DBB, 5, 0,  DB);
        vecs[9]  = mk(1, 0, 1, 0,    1, 0, 2, 0,     1, 0, 0, 0, 0, 2, DBB, 1, 0,  DB);
        vecs[10] = mk(1, 0, 1, 0,    1, 0, 2, 0,     0, 0, 0, 0, 0, 2, DBB, 1, 0,  DB);
        vecs[11] = mk(1, 0, 1, 0,    1, 0, 2, 0,     0, 0, 1, 0, 0, 2, DBB, 1, DA, DB);
        vecs[12] = mk(1, 0, 1, 0,    1, 0, 2, 0,     0, 1, 0, 0, 0, 2, DBB, 2, DA, DB);
        vecs[13] = mk(1, 0, 1, 0,    1, 0, 2, 0,     0, 0, 0, 0, 0, 2, DBB, 2, DA, DB);
        vecs[14] = mk(1, 0, 1, 0,    1, 0, 2, 0,     0, 0, 0, 1, 0, 2, DBB, 2, DA, DBB);
        vecs[15] = mk(1, 0, 1, 0,    1, 0, 2, 0,     1, 0, 0, 0, 0, 2, DBB, 1, DA, DBB);
        vecs[16] = mk(1, 0, 1, 0,    1, 0, 2, 0,     0, 0, 0, 0, 0, 2, DBB, 1, DA, DBB);
        vecs[17] = mk(1, 0, 1, 0,    1, 0, 2, 0,     0, 0, 1, 0, 0, 2, DBB, 1, DA, DBB);
        vecs[18] = mk(0, 0, 0, 0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 2, DBB, 1, DA, DBB);
        vecs[19] = mk(1, 0, 5, 0,    0, 0, 0, 0,     1, 0, 0, 0, 0, 2, DBB, 5, DA, DBB);
        vecs[20] = mk(0, 0, 0, 0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 2, DBB, 5, DA, DBB);
        vecs[21] = mk(0, 0, 0, 0,    0, 0, 0, 0,     0, 0, 1, 0, 0, 2, DBB, 5, DB, DBB);

        // Reset held with random inputs: every output of both builds stays 0.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), $urandom, $urandom,
                  1'($urandom), 1'($urandom), $urandom, $urandom);
            tick();
            check($sformatf("reset_outs_a%0d", i), outs_a(), 192'd0);
            check($sformatf("reset_outs_b%0d", i), outs_b(), 192'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle_wea%0d", i), 192'({a_wea, b_wea}), 192'd0);
        end

        // Cycle table on the RD_LAT=1 build: write, read-after-write, tie write, contention reads.
        for (int k = 0; k < 22; k++) begin
            drive(vecs[k].r0, vecs[k].w0, vecs[k].a0, vecs[k].d0,
                  vecs[k].r1, vecs[k].w1, vecs[k].a1, vecs[k].d1);
            tick();
            check($sformatf("vec%0d", k), outs_a(), exp_of(vecs[k]));
        end

        // RD_LAT=3 build from a clean reset.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        drive(1, 1, 9, D9, 0, 0, 0, 0);
        wait_gnt_b(0, ok);
        check("b_wr_gnt", 192'(ok), 192'd1);
        check("b_wr_drive", 192'({b_wea, b_addra, b_dina}), 192'({1'b1, 32'd9, D9}));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("b_wr_pulse_end", 192'({b_wea, b_m0_gnt}), 192'd0);

        drive(1, 0, 9, 0, 1, 0, 2, 0);
        wait_gnt_b(0, ok);
        check("b_rd_gnt", 192'(ok), 192'd1);
        drive(0, 0, 0, 0, 1, 0, 2, 0);
        lat = 0;
        saw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (b_m0_gnt || b_m1_gnt) saw = 1'b1;
            if (b_m0_rvalid) begin
                lat = i;
                break;
            end
        end
        check("b_rd_latency", 192'(lat), 192'd4);
        check("b_no_gnt_in_wait", 192'(saw), 192'd0);
        check("b_rdata0", 192'(b_m0_rdata), 192'(D9));
        check("b_m1_rvalid_quiet", 192'(b_m1_rvalid), 192'd0);
        tick();
        check("b_m1_gnt_after_wait", 192'({b_m0_gnt, b_m1_gnt}), 192'b01);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick();

        // Reset in the middle of an m0 read (pointer last = m0 before reset).
        drive(1, 0, 9, 0, 0, 0, 0, 0);
        wait_gnt_b(0, ok);
        check("b_mid_gnt", 192'(ok), 192'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outs_b", outs_b(), 192'd0);
        check("mid_reset_outs_a", outs_a(), 192'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b_m0_rvalid || b_m1_rvalid || a_m0_rvalid || a_m1_rvalid) saw = 1'b1;
        end
        check("no_rvalid_after_reset", 192'(saw), 192'd0);

        drive(1, 0, 9, 0, 1, 0, 9, 0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b_m0_gnt || b_m1_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_tie_after_reset", 192'({ok, b_m0_gnt, b_m1_gnt}), 192'b110);
        drive(0, 0, 0, 0, 1, 0, 9, 0);
        wait_gnt_b(1, ok);
        check("b_m1_served", 192'(ok), 192'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (b_m1_rvalid) begin
                lat = i;
                break;
            end
        end
        check("b_m1_latency", 192'(lat), 192'd4);
        check("b_m1_rdata", 192'(b_m1_rdata), 192'(D9));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
